// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite single-port memory slave with programmable read/write response latency.
// One transaction in flight at a time. Out-of-range addresses answer SLVERR.
module axi_lite_mem_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    WR_LATENCY = 1,
  parameter int                    RD_LATENCY = 2
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int         IDX_W       = $clog2(MEM_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  if (WR_LATENCY < 1 || WR_LATENCY > 15) begin : g_bad_wr_latency
    $error("WR_LATENCY must be within 1..15");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_rd_latency
    $error("RD_LATENCY must be within 1..15");
  end
  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("DATA_WIDTH must be 32");
  end

  typedef enum logic [2:0] {
    IDLE, WR_COLLECT, WR_WAIT, WR_RESP, RD_WAIT, RD_RESP
  } state_t;

  // Every channel transfers on a cycle where valid && ready are both high at the rising edge;
  // valid never waits on ready, and once raised by this slave stays high with stable payload until taken.
  state_t                  state_q, state_d;
  logic [3:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    aw_have_q, w_have_q;
  logic [1:0]              bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    ready_en_q;
  logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

  logic                    aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0]   word_off;
  logic                    addr_ok;
  logic [IDX_W-1:0]        mem_idx;
  logic                    wr_commit, rd_capture;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  assign word_off = (addr_q - BASE_ADDR) >> 2;
  assign addr_ok  = (addr_q >= BASE_ADDR) && (word_off < ADDR_WIDTH'(MEM_WORDS));
  assign mem_idx  = word_off[IDX_W-1:0];

  assign wr_commit  = (state_q == WR_WAIT) && (cnt_q == 4'd0);
  assign rd_capture = (state_q == RD_WAIT) && (cnt_q == 4'd0);

  // ready_en_q keeps every ready low while reset is held and for the first cycle after it.
  assign s_axi_awready = ready_en_q && ((state_q == IDLE) || ((state_q == WR_COLLECT) && !aw_have_q));
  assign s_axi_wready  = ready_en_q && ((state_q == IDLE) || ((state_q == WR_COLLECT) && !w_have_q));
  assign s_axi_arready = ready_en_q && (state_q == IDLE) && !s_axi_awvalid && !s_axi_wvalid;
  assign s_axi_bvalid  = (state_q == WR_RESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = (state_q == RD_RESP);
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (aw_hs && w_hs)      state_d = WR_WAIT;
        else if (aw_hs || w_hs) state_d = WR_COLLECT;
        else if (ar_hs)         state_d = RD_WAIT;
      end
      WR_COLLECT: if ((aw_have_q || aw_hs) && (w_have_q || w_hs)) state_d = WR_WAIT;
      WR_WAIT:    if (cnt_q == 4'd0) state_d = WR_RESP;
      WR_RESP:    if (s_axi_bready)  state_d = IDLE;
      RD_WAIT:    if (cnt_q == 4'd0) state_d = RD_RESP;
      RD_RESP:    if (s_axi_rready)  state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_have_q  <= 1'b0;
      w_have_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      if (aw_hs) begin
        addr_q    <= s_axi_awaddr;
        aw_have_q <= 1'b1;
      end else if (ar_hs) begin
        addr_q <= s_axi_araddr;
      end
      if (w_hs) begin
        wdata_q  <= s_axi_wdata;
        wstrb_q  <= s_axi_wstrb;
        w_have_q <= 1'b1;
      end
      // Latency counter loads on entry to a wait state, then counts down to zero.
      if (state_d == WR_WAIT && state_q != WR_WAIT)      cnt_q <= 4'(WR_LATENCY - 1);
      else if (state_d == RD_WAIT && state_q != RD_WAIT) cnt_q <= 4'(RD_LATENCY - 1);
      else if (cnt_q != 4'd0)                            cnt_q <= cnt_q - 4'd1;
      if (wr_commit) begin
        bresp_q   <= addr_ok ? RESP_OKAY : RESP_SLVERR;
        aw_have_q <= 1'b0;
        w_have_q  <= 1'b0;
      end
      if (rd_capture) begin
        rresp_q <= addr_ok ? RESP_OKAY : RESP_SLVERR;
        rdata_q <= addr_ok ? mem[mem_idx] : '0;
      end
    end
  end

  // Storage is deliberately left out of reset; only strobed lanes of in-range words change.
  always_ff @(posedge s_axi_aclk) begin
    if (wr_commit && addr_ok) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (wstrb_q[i]) mem[mem_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/axi_lite_mem_responder.md
Name: axi_lite_mem_responder

Overview:
- AXI4-Lite slave memory model, single-port. It answers the master port that the L2 cache drives toward main memory.
- Word-addressed storage with byte-lane write strobes. Read and write response latencies are programmable.
- Range-checked address decode.
- Serves one transaction at a time, so cache fill/write-back sequences see realistic, deterministic latency.

Parameters:
- ADDR_WIDTH, 32, address width of AW/AR channels.
- DATA_WIDTH, 32, data width; fixed at 32 (4 strobe lanes).
- MEM_WORDS, 4096, number of 32-bit words stored.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WR_LATENCY, 1, cycles from both AW and W captured to bvalid rising; legal range 1..15.
- RD_LATENCY, 2, cycles from AR handshake to rvalid rising; legal range 1..15.

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  asynchronous active-low reset
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  DATA_WIDTH/8  byte enables
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response: OKAY=2'b00, SLVERR=2'b10
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready

Behaviour:
- Clocking and reset: one clock domain on s_axi_aclk. Reset is asynchronous and active-low on s_axi_aresetn.
- Reset values: all ready and valid outputs 0, bresp/rresp 2'b00, rdata 0, FSM in IDLE, latency counter 0.
- Memory array is not cleared by reset; contents are undefined until written.
- FSM states: IDLE, WR_COLLECT, WR_WAIT, WR_RESP, RD_WAIT, RD_RESP.
- IDLE: awready=1 and wready=1. arready = !awvalid && !wvalid, so writes win when a write and a read are presented in the same cycle.
  - AW and W captured in the same cycle -> WR_WAIT.
  - Only one of AW/W captured -> WR_COLLECT.
  - AR captured -> RD_WAIT.
- WR_COLLECT: ready is held high only on the missing channel; arready=0. The missing half arrives -> WR_WAIT.
- WR_WAIT: counter loads WR_LATENCY-1 on entry and decrements each cycle. At 0 -> commit the write and enter WR_RESP.
- Write commit: for each lane i with wstrb[i]=1, write byte i of the word at index (awaddr-BASE_ADDR)>>2. Lanes with wstrb=0 are unchanged.
- WR_RESP: bvalid=1 with bresp held stable until bready. Handshake -> IDLE. The next AW/W can be accepted no earlier than the cycle after the B handshake.
- RD_WAIT: counter loads RD_LATENCY-1 at AR capture. At 0 -> RD_RESP, with rdata/rresp registered that cycle.
- RD_RESP: rvalid=1 with rdata/rresp stable until rready. Handshake -> IDLE; rvalid drops the next cycle.
- Latency: WR_LATENCY=1 gives bvalid in the cycle after the last of AW/W is captured. RD_LATENCY=N gives rvalid rising N cycles after the AR handshake edge.
- Address decode:
  - awaddr/araddr[1:0] are ignored (word access).
  - An address below BASE_ADDR or at/above BASE_ADDR+4*MEM_WORDS is out of range -> resp SLVERR.
  - Out-of-range writes do not modify memory. Out-of-range reads return rdata=0.
- Single outstanding transaction: no new address is accepted while any write or read is in flight.
- bready or rready held low: stall indefinitely with outputs stable.
- A read issued after a write's B handshake to the same address returns the new data.
- Reset mid-operation: the transaction is abandoned and no B/R response is issued. A write not yet committed leaves memory unchanged; a committed write persists.
- A latency parameter outside 1..15 must fail elaboration via a static assertion.

Test Plan:
- Write 32'hDEAD_BEEF to 0x10, wstrb=4'hF, bready=1 -> bvalid 1 cycle after AW/W, bresp=00. Read 0x10 -> rvalid 2 cycles after AR handshake, rdata=32'hDEAD_BEEF, rresp=00.
- Write 32'hA5A5_A5A5 to 0x20, then write 32'h1122_3344 to 0x20 with wstrb=4'b0101 -> read 0x20 returns 32'hA522_A544.
- W presented 3 cycles before AW (address 0x40, data 0x55) -> W accepted in IDLE, arready=0 throughout, AW accepted later, bvalid 1 cycle after the AW handshake, memory[0x40]=0x55.
- awvalid and arvalid asserted in the same cycle (write 0x77 to 0x8, read 0x8) -> write serviced first. The read is accepted only after the B handshake and returns 0x77.
- Read address BASE_ADDR+4*MEM_WORDS -> rresp=2'b10, rdata=0. Write to the same address -> bresp=2'b10 and no memory change.
- bready held 0 for 5 cycles -> bvalid stays 1 with bresp stable; awready=0 and arready=0 throughout. Assert reset during RD_WAIT -> rvalid never rises and all outputs return to 0 asynchronously.
